multicycle_control: RTL
=======================

# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath: it steps the shared ALU, the unified instruction/data memory and the register file through fetch, decode, execute, memory and write-back states. It supports add/addu/sub/subu, addi/addiu, lw, sw, beq and j, stalls on a memory ready handshake, and counts retired instructions. It sits between the instruction register and the datapath muxes and enables, replacing single-cycle decode.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_run  in  1  start/continue execution; sampled at instruction boundaries
- i_instrCode  in  12  IR output {opcode[31:26], funct[5:0]}, valid from DECODE onward
- i_memReady  in  1  memory access completes this cycle
- o_pcWrite  out  1  unconditional PC load
- o_pcWriteCond  out  1  PC load if ALU zero
- o_pcSrc  out  2  0 ALU result, 1 ALUOut register (branch target), 2 jump target
- o_iorD  out  1  memory address: 0 PC, 1 ALUOut
- o_memRead  out  1  memory read request
- o_memWrite  out  1  memory write request
- o_irWrite  out  1  IR load
- o_regDst  out  1  1 rd, 0 rt
- o_memToReg  out  1  1 MDR, 0 ALUOut
- o_regWrite  out  1  register file write
- o_aluSrcA  out  1  0 PC, 1 rs
- o_aluSrcB  out  2  0 rt, 1 const 4, 2 extended imm, 3 extended imm<<2
- o_aluOp  out  2  0 ADD, 1 SUB, 2 from funct
- o_ExtOp  out  1  sign-extend enable
- o_ovfEn  out  1  overflow trap enable (add, sub, addi only)
- o_illegal  out  1  one-cycle pulse on unsupported opcode/funct
- o_retired  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_ACC, WB_MEM, BRANCH, JUMP. Outputs are 0 unless listed.
- IDLE: all outputs 0; -> FETCH when i_run=1.
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=1, aluOp=ADD. irWrite=1 and pcWrite=1 only in the cycle where i_memReady=1 (Mealy); then -> DECODE; otherwise hold.
- DECODE: aluSrcA=0, aluSrcB=3, ExtOp=1, aluOp=ADD (branch target to ALUOut). Latch the instruction class.
  - opcode 0 with funct 32–35 -> EXEC_R; 8/9 -> EXEC_I; 35/43 -> MEM_ADDR; 4 -> BRANCH; 2 -> JUMP.
  - Anything else: o_illegal=1, not retired, -> boundary.
- EXEC_R: aluSrcA=1, aluSrcB=0, aluOp=FUNCT, ovfEn=1 for funct 32/34. -> WB_R.
- WB_R: regDst=1, regWrite=1; retire.
- EXEC_I: aluSrcA=1, aluSrcB=2, ExtOp=1, aluOp=ADD, ovfEn=1 for opcode 8. -> WB_I.
- WB_I: regDst=0, regWrite=1; retire.
- MEM_ADDR: aluSrcA=1, aluSrcB=2, ExtOp=1, aluOp=ADD. -> MEM_ACC.
- MEM_ACC: iorD=1, memRead=1 (lw) or memWrite=1 (sw), held stable until i_memReady. Then lw -> WB_MEM; sw retires.
- WB_MEM: regDst=0, memToReg=1, regWrite=1; retire.
- BRANCH: aluSrcA=1, aluSrcB=0, aluOp=SUB, pcWriteCond=1, pcSrc=1; retire.
- JUMP: pcWrite=1, pcSrc=2; retire.
- Boundary: -> FETCH if i_run=1, else IDLE.
- Retire: o_retired increments by 1 in the registered update at the end of the retiring state. It wraps modulo 2^CNT_W.

## Timing
- Reset, asserted at any time including mid-access: state=IDLE, o_retired=0, all outputs 0 immediately (asynchronous). An aborted write is not completed.
- Latency with i_memReady tied high, FETCH to the next FETCH: R-type 4, addi/addiu 4, lw 5, sw 4, beq 3, j 3, illegal 2 cycles.
- Each low cycle of i_memReady in FETCH or MEM_ACC adds one cycle. i_memReady is ignored in every other state.
- i_run deassertion mid-instruction: the current instruction completes, then the FSM goes to IDLE.
- i_instrCode is read only in DECODE. Its class is latched, so IR changes afterwards have no effect.

## Structure
- Package mc_pkg holds:
  - the state enum;
  - opcode constants (R=0, J=2, BEQ=4, ADDI=8, ADDIU=9, LW=35, SW=43) and funct constants (32–35);
  - aluOp, aluSrcB and pcSrc encodings.
- Sub-module instr_classify (combinational) maps i_instrCode to {class, ovfEn, legal} and is used in DECODE.

## Test plan
- Reset, then i_run=1, memReady=1, IR=add (0x000,0x20): states FETCH, DECODE, EXEC_R, WB_R; regDst=1, regWrite=1 in cycle 4; ovfEn=1 in EXEC_R; o_retired=1.
- lw (opcode 35) with memReady low for 3 cycles in MEM_ACC: memRead=1, iorD=1 held 4 cycles; WB_MEM memToReg=1; total 8 cycles.
- beq then j: beq gives pcWriteCond=1, pcSrc=1, aluOp=SUB in cycle 3; j gives pcWrite=1, pcSrc=2 in cycle 3; o_retired=2.
- IR opcode 0x3F: o_illegal pulses 1 cycle in DECODE, back to FETCH, o_retired unchanged.
- Fault cases:
  - i_rst_n low mid-sw in MEM_ACC: memWrite drops to 0 in the same cycle, o_retired=0, IDLE.
  - i_run low during addu EXEC_R: WB_R completes, then IDLE with all outputs 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: FSM states,
// instruction classes, opcode/funct values and datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_ACC  = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef enum logic [2:0] {
        CL_R   = 3'd0,
        CL_I   = 3'd1,
        CL_LW  = 3'd2,
        CL_SW  = 3'd3,
        CL_BEQ = 3'd4,
        CL_J   = 3'd5
    } class_e;

    localparam logic [5:0] OP_R     = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_SUBU = 6'd35;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

endpackage

// File: rtl/instr_classify.sv
// Combinational decode of {opcode, funct} into an instruction class,
// the overflow-trap enable and a legality flag.
module instr_classify
    import mc_pkg::*;
(
    input  logic [11:0] i_instrCode,
    output logic [2:0]  o_class,
    output logic        o_ovfEn,
    output logic        o_legal
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = i_instrCode[11:6];
    assign funct  = i_instrCode[5:0];

    always_comb begin
        o_class = CL_R;
        o_ovfEn = 1'b0;
        o_legal = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct >= FN_ADD && funct <= FN_SUBU) begin
                    o_legal = 1'b1;
                    o_class = CL_R;
                    o_ovfEn = (funct == FN_ADD) || (funct == FN_SUB);
                end
            end
            OP_ADDI: begin
                o_legal = 1'b1;
                o_class = CL_I;
                o_ovfEn = 1'b1;
            end
            OP_ADDIU: begin
                o_legal = 1'b1;
                o_class = CL_I;
            end
            OP_LW: begin
                o_legal = 1'b1;
                o_class = CL_LW;
            end
            OP_SW: begin
                o_legal = 1'b1;
                o_class = CL_SW;
            end
            OP_BEQ: begin
                o_legal = 1'b1;
                o_class = CL_BEQ;
            end
            OP_J: begin
                o_legal = 1'b1;
                o_class = CL_J;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps ALU, unified memory and register file through
// fetch/decode/execute/memory/write-back and counts retired instructions.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [11:0]      i_instrCode,
    input  logic             i_memReady,
    output logic             o_pcWrite,
    output logic             o_pcWriteCond,
    output logic [1:0]       o_pcSrc,
    output logic             o_iorD,
    output logic             o_memRead,
    output logic             o_memWrite,
    output logic             o_irWrite,
    output logic             o_regDst,
    output logic             o_memToReg,
    output logic             o_regWrite,
    output logic             o_aluSrcA,
    output logic [1:0]       o_aluSrcB,
    output logic [1:0]       o_aluOp,
    output logic             o_ExtOp,
    output logic             o_ovfEn,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired,
    output logic [3:0]       o_state
);

    state_e           state_q, state_d;
    class_e           cls_q, cls_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;
    logic             boundary;
    logic [2:0]       dec_class;
    logic             dec_ovf;
    logic             dec_legal;

    instr_classify u_classify (
        .i_instrCode (i_instrCode),
        .o_class     (dec_class),
        .o_ovfEn     (dec_ovf),
        .o_legal     (dec_legal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= CL_R;
            ovf_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ovf_q     <= ovf_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cls_d         = cls_q;
        ovf_d         = ovf_q;
        retired_d     = retired_q;
        retire        = 1'b0;
        boundary      = 1'b0;
        o_pcWrite     = 1'b0;
        o_pcWriteCond = 1'b0;
        o_pcSrc       = PC_ALU;
        o_iorD        = 1'b0;
        o_memRead     = 1'b0;
        o_memWrite    = 1'b0;
        o_irWrite     = 1'b0;
        o_regDst      = 1'b0;
        o_memToReg    = 1'b0;
        o_regWrite    = 1'b0;
        o_aluSrcA     = 1'b0;
        o_aluSrcB     = SRCB_RT;
        o_aluOp       = ALU_ADD;
        o_ExtOp       = 1'b0;
        o_ovfEn       = 1'b0;
        o_illegal     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_run) state_d = S_FETCH;
            end
            S_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = SRCB_FOUR;
                if (i_memReady) begin
                    o_irWrite = 1'b1;
                    o_pcWrite = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut while decoding.
                o_aluSrcB = SRCB_IMM_SH;
                o_ExtOp   = 1'b1;
                cls_d     = class_e'(dec_class);
                ovf_d     = dec_ovf;
                if (!dec_legal) begin
                    o_illegal = 1'b1;
                    boundary  = 1'b1;
                end else begin
                    case (class_e'(dec_class))
                        CL_R:          state_d = S_EXEC_R;
                        CL_I:          state_d = S_EXEC_I;
                        CL_LW, CL_SW:  state_d = S_MEM_ADDR;
                        CL_BEQ:        state_d = S_BRANCH;
                        CL_J:          state_d = S_JUMP;
                        default:       boundary = 1'b1;
                    endcase
                end
            end
            S_EXEC_R: begin
                o_aluSrcA = 1'b1;
                o_aluOp   = ALU_FUNCT;
                o_ovfEn   = ovf_q;
                state_d   = S_WB_R;
            end
            S_WB_R: begin
                o_regDst   = 1'b1;
                o_regWrite = 1'b1;
                retire     = 1'b1;
            end
            S_EXEC_I: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = SRCB_IMM;
                o_ExtOp   = 1'b1;
                o_ovfEn   = ovf_q;
                state_d   = S_WB_I;
            end
            S_WB_I: begin
                o_regWrite = 1'b1;
                retire     = 1'b1;
            end
            S_MEM_ADDR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = SRCB_IMM;
                o_ExtOp   = 1'b1;
                state_d   = S_MEM_ACC;
            end
            S_MEM_ACC: begin
                o_iorD     = 1'b1;
                o_memRead  = (cls_q == CL_LW);
                o_memWrite = (cls_q == CL_SW);
                if (i_memReady) begin
                    if (cls_q == CL_LW) state_d = S_WB_MEM;
                    else                retire  = 1'b1;
                end
            end
            S_WB_MEM: begin
                o_memToReg = 1'b1;
                o_regWrite = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                o_aluSrcA     = 1'b1;
                o_aluOp       = ALU_SUB;
                o_pcWriteCond = 1'b1;
                o_pcSrc       = PC_ALUOUT;
                retire        = 1'b1;
            end
            S_JUMP: begin
                o_pcWrite = 1'b1;
                o_pcSrc   = PC_JUMP;
                retire    = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // i_run is only honoured here, between instructions.
        if (retire) begin
            retired_d = retired_q + CNT_W'(1);
            boundary  = 1'b1;
        end
        if (boundary) state_d = i_run ? S_FETCH : S_IDLE;
    end

    assign o_retired = retired_q;
    assign o_state   = state_q;

endmodule
